// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the instruction fetcher: opcodes, prediction flag,
// queue entry layout and fetch FSM states.
package inst_fetcher_pkg;

  // Same opcode encodings as the decoder.
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic JUMP     = 1'b1;
  localparam logic NOT_JUMP = 1'b0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pd;
  } iq_entry_t;

  typedef struct packed {
    logic [31:0] npc;
    logic        pd;
  } pred_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DROP
  } fetch_state_t;

endpackage

// File: rtl/inst_fetcher_if.sv
// Fetcher bus bundle: memory-controller request/reply, ROB redirect, dispatch stall
// and the decoder-facing instruction stream.
interface inst_fetcher_if;
  logic        mc_en;
  logic [31:0] mc_addr;
  logic        mc_done;
  logic [31:0] mc_inst;
  logic        dp_stall;
  logic        rob_flush;
  logic [31:0] rob_pc;
  logic        dec_en;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_pd;

  modport master (
    output mc_en, mc_addr,
    input  mc_done, mc_inst,
    input  dp_stall, rob_flush, rob_pc,
    output dec_en, dec_inst, dec_pc, dec_pd
  );

  modport slave (
    input  mc_en, mc_addr,
    output mc_done, mc_inst,
    output dp_stall, rob_flush, rob_pc,
    input  dec_en, dec_inst, dec_pc, dec_pd
  );
endinterface

// File: rtl/inst_fetcher_queue.sv
// In-order instruction queue: DEPTH-entry synchronous FIFO with clear, gated by en.
// The head entry is read combinationally; the consumer registers it on pop.
module inst_fetcher_queue
  import inst_fetcher_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  logic      clear,
  input  logic      push,
  input  iq_entry_t push_data,
  input  logic      pop,
  output iq_entry_t head,
  output logic [AW:0] count
);

  iq_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;

  always_ff @(posedge clk) begin
    if (en && push && !clear) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (en) begin
      if (clear) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: one outstanding memory request, static next-PC prediction,
// in-order queue toward the decoder, and ROB redirect handling.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int IQ_DEPTH = 8,
  parameter int IQ_AW    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  inst_fetcher_if.master bus
);

  localparam logic [IQ_AW:0] DEPTH_C = (IQ_AW + 1)'(IQ_DEPTH);

  // JAL and backward conditional branches are predicted taken; everything else falls through.
  function automatic pred_t predict(input logic [31:0] inst, input logic [31:0] pc);
    pred_t       p;
    logic [31:0] jimm;
    logic [31:0] bimm;
    jimm  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    bimm  = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    p.npc = pc + 32'd4;
    p.pd  = NOT_JUMP;
    if (inst[6:0] == OPC_JAL) begin
      p.npc = pc + jimm;
      p.pd  = JUMP;
    end else if (inst[6:0] == OPC_BRANCH && inst[31]) begin
      p.npc = pc + bimm;
      p.pd  = JUMP;
    end
    return p;
  endfunction

  fetch_state_t   state_reg;
  logic [31:0]    pc_reg;
  logic           mc_en_reg;
  logic [31:0]    mc_addr_reg;
  logic           dec_en_reg;
  logic [31:0]    dec_inst_reg;
  logic [31:0]    dec_pc_reg;
  logic           dec_pd_reg;

  pred_t          pred;
  iq_entry_t      push_data;
  iq_entry_t      head;
  logic [IQ_AW:0] count;
  logic           push;
  logic           pop;

  assign pred      = predict(bus.mc_inst, mc_addr_reg);
  assign push      = (state_reg == ST_WAIT) && bus.mc_done && !bus.rob_flush;
  assign pop       = !bus.dp_stall && !bus.rob_flush && (count != '0);
  assign push_data = '{inst: bus.mc_inst, pc: mc_addr_reg, pd: pred.pd};

  inst_fetcher_queue #(
    .DEPTH (IQ_DEPTH),
    .AW    (IQ_AW)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .clear     (bus.rob_flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= '0;
      mc_en_reg    <= 1'b0;
      mc_addr_reg  <= '0;
      dec_en_reg   <= 1'b0;
      dec_inst_reg <= '0;
      dec_pc_reg   <= '0;
      dec_pd_reg   <= NOT_JUMP;
    end else if (rdy) begin
      dec_en_reg <= 1'b0;
      if (bus.rob_flush) begin
        // A reply still in flight must be swallowed, hence DROP when none arrived yet.
        pc_reg    <= bus.rob_pc;
        mc_en_reg <= 1'b0;
        if (state_reg == ST_WAIT) begin
          state_reg <= bus.mc_done ? ST_IDLE : ST_DROP;
        end
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (count < DEPTH_C) begin
              state_reg   <= ST_WAIT;
              mc_en_reg   <= 1'b1;
              mc_addr_reg <= pc_reg;
            end
          end
          ST_WAIT: begin
            if (bus.mc_done) begin
              state_reg <= ST_IDLE;
              mc_en_reg <= 1'b0;
              pc_reg    <= pred.npc;
            end
          end
          ST_DROP: begin
            if (bus.mc_done) state_reg <= ST_IDLE;
          end
          default: begin
            state_reg <= ST_IDLE;
            mc_en_reg <= 1'b0;
          end
        endcase
        if (pop) begin
          dec_en_reg   <= 1'b1;
          dec_inst_reg <= head.inst;
          dec_pc_reg   <= head.pc;
          dec_pd_reg   <= head.pd;
        end
      end
    end
  end

  // A pulse registered just before a freeze stays pending and is seen once rdy returns.
  assign bus.mc_en    = mc_en_reg;
  assign bus.mc_addr  = mc_addr_reg;
  assign bus.dec_en   = dec_en_reg & rdy;
  assign bus.dec_inst = dec_inst_reg;
  assign bus.dec_pc   = dec_pc_reg;
  assign bus.dec_pd   = dec_pd_reg;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed scoreboard bench for inst_fetcher with a two-cycle-latency memory model.
module tb_inst_fetcher;

  localparam logic [31:0] ADDI  = 32'h00108093;  // addi x1,x1,1
  localparam logic [31:0] JAL16 = 32'h0100006F;  // jal x0,+16
  localparam logic [31:0] BEQM8 = 32'hFE000CE3;  // beq x0,x0,-8
  localparam logic [31:0] BNEP8 = 32'h00001463;  // bne x0,x0,+8

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  inst_fetcher_if bus();

  inst_fetcher #(.IQ_DEPTH(8), .IQ_AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [logic [31:0]];
  exp_t        dec_q[$];
  logic [31:0] addr_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          check_en = 1'b0;

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    if (imem.exists(a)) return imem[a];
    return ADDI;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_dec(input logic [31:0] inst, input logic [31:0] pc, input logic pd);
    dec_q.push_back('{inst: inst, pc: pc, pd: pd});
  endtask

  // Memory controller model: latch a request, reply 2 cycles later, frozen by rdy.
  initial begin
    bit          busy;
    int          cnt;
    logic [31:0] req_addr;
    bit          rdy_e;
    bit          rst_e;
    busy = 0; cnt = 0; req_addr = '0;
    bus.mc_done = 1'b0;
    bus.mc_inst = '0;
    forever begin
      @(posedge clk);
      rdy_e = rdy;
      rst_e = rst;
      #1;
      if (rst_e) begin
        bus.mc_done = 1'b0;
        busy = 0;
      end else if (rdy_e) begin
        if (bus.mc_done) begin
          bus.mc_done = 1'b0;
        end else if (busy) begin
          cnt++;
          if (cnt == 2) begin
            bus.mc_done = 1'b1;
            bus.mc_inst = fetch_word(req_addr);
            busy = 0;
          end
        end else if (bus.mc_en) begin
          busy = 1;
          cnt = 0;
          req_addr = bus.mc_addr;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each decoder pulse and each new memory request.
  initial begin
    logic mc_en_prev;
    exp_t e;
    mc_en_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (check_en && !rst) begin
        if (bus.dec_en) begin
          $display("dec  pc=%h inst=%h pd=%0d", bus.dec_pc, bus.dec_inst, bus.dec_pd);
          if (dec_q.size() > 0) begin
            e = dec_q.pop_front();
            checks++;
            if ({bus.dec_inst, bus.dec_pc, bus.dec_pd} !== {e.inst, e.pc, e.pd}) begin
              errors++;
              $display("FAIL dec_out: got pc=%h inst=%h pd=%0d expected pc=%h inst=%h pd=%0d",
                       bus.dec_pc, bus.dec_inst, bus.dec_pd, e.pc, e.inst, e.pd);
            end
          end
        end
        if (bus.mc_en && !mc_en_prev) begin
          $display("req  addr=%h", bus.mc_addr);
          if (addr_q.size() > 0) check("mc_addr", bus.mc_addr, addr_q.pop_front());
        end
      end
      mc_en_prev = bus.mc_en;
    end
  end

  task automatic begin_test(input string name);
    $display("test %s", name);
    check_en     = 1'b0;
    rst          = 1'b1;
    rdy          = 1'b1;
    bus.dp_stall = 1'b0;
    bus.rob_flush = 1'b0;
    bus.rob_pc   = '0;
    dec_q.delete();
    addr_q.delete();
    imem.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mc_en", 32'(bus.mc_en), 32'd0);
    check("rst_mc_addr", bus.mc_addr, 32'd0);
    check("rst_dec_en", 32'(bus.dec_en), 32'd0);
    check("rst_dec_inst", bus.dec_inst, 32'd0);
    check("rst_dec_pc", bus.dec_pc, 32'd0);
    check("rst_dec_pd", 32'(bus.dec_pd), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic go();
    rst = 1'b0;
    check_en = 1'b1;
  endtask

  task automatic go_at(input logic [31:0] target);
    rst = 1'b0;
    check_en = 1'b1;
    bus.rob_flush = 1'b1;
    bus.rob_pc = target;
    @(posedge clk); #1;
    bus.rob_flush = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (dec_q.size() == 0 && addr_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    checks++;
    if (dec_q.size() != 0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d dec and %0d addr pending expected 0", dec_q.size(), addr_q.size());
    end
  endtask

  // Polls at posedge+1 for the first cycle of the request to addr.
  task automatic wait_req(input logic [31:0] a, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk); #1;
      if (bus.mc_en && bus.mc_addr == a) found = 1;
    end
    check("wait_req", 32'(found), 32'd1);
  endtask

  initial begin
    bus.dp_stall = 1'b0;
    bus.rob_flush = 1'b0;
    bus.rob_pc = '0;
    #1;

    begin_test("sequential");
    for (int i = 0; i < 3; i++) begin
      addr_q.push_back(32'(i * 4));
      exp_dec(ADDI, 32'(i * 4), 1'b0);
    end
    go();
    wait_drain(60);

    begin_test("jal");
    imem[32'h10] = JAL16;
    for (int i = 0; i < 5; i++) addr_q.push_back(32'(i * 4));
    addr_q.push_back(32'h20);
    for (int i = 0; i < 4; i++) exp_dec(ADDI, 32'(i * 4), 1'b0);
    exp_dec(JAL16, 32'h10, 1'b1);
    exp_dec(ADDI, 32'h20, 1'b0);
    go();
    wait_drain(80);

    begin_test("beq_back");
    imem[32'h40] = BEQM8;
    addr_q = '{32'h40, 32'h38, 32'h3C, 32'h40, 32'h38};
    exp_dec(BEQM8, 32'h40, 1'b1);
    exp_dec(ADDI, 32'h38, 1'b0);
    exp_dec(ADDI, 32'h3C, 1'b0);
    exp_dec(BEQM8, 32'h40, 1'b1);
    go_at(32'h40);
    wait_drain(80);

    begin_test("bne_fwd");
    imem[32'h40] = BNEP8;
    addr_q = '{32'h40, 32'h44, 32'h48};
    exp_dec(BNEP8, 32'h40, 1'b0);
    exp_dec(ADDI, 32'h44, 1'b0);
    go_at(32'h40);
    wait_drain(60);

    begin_test("stall_fill");
    bus.dp_stall = 1'b1;
    for (int i = 0; i < 10; i++) addr_q.push_back(32'(i * 4));
    for (int i = 0; i < 9; i++) exp_dec(ADDI, 32'(i * 4), 1'b0);
    go();
    begin
      bit idle_ok = 1;
      int run = 0;
      for (int i = 0; i < 100 && addr_q.size() > 2; i++) @(posedge clk);
      for (int i = 0; i < 10 && bus.mc_en; i++) @(posedge clk);
      repeat (12) begin
        @(negedge clk);
        if (bus.mc_en || bus.dec_en) idle_ok = 0;
      end
      check("full_idle", 32'(idle_ok), 32'd1);
      check("full_reqs", 32'(addr_q.size()), 32'd2);
      @(posedge clk); #1;
      bus.dp_stall = 1'b0;
      for (int i = 0; i < 10 && !bus.dec_en; i++) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (bus.dec_en) run++;
        @(negedge clk);
      end
      check("b2b_issue", 32'(run), 32'd8);
    end
    @(posedge clk); #1;
    wait_drain(60);

    begin_test("flush_wait");
    addr_q = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
    exp_dec(ADDI, 32'h0, 1'b0);
    exp_dec(ADDI, 32'h4, 1'b0);
    exp_dec(ADDI, 32'h100, 1'b0);
    exp_dec(ADDI, 32'h104, 1'b0);
    go();
    wait_req(32'h8, 60);
    bus.rob_flush = 1'b1;
    bus.rob_pc = 32'h100;
    @(posedge clk); #1;
    bus.rob_flush = 1'b0;
    wait_drain(60);

    begin_test("flush_done");
    addr_q = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
    exp_dec(ADDI, 32'h0, 1'b0);
    exp_dec(ADDI, 32'h4, 1'b0);
    exp_dec(ADDI, 32'h100, 1'b0);
    exp_dec(ADDI, 32'h104, 1'b0);
    go();
    begin
      bit found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
        @(posedge clk); #2;
        if (bus.mc_done && bus.mc_addr == 32'h8) found = 1;
      end
      check("wait_done", 32'(found), 32'd1);
    end
    bus.rob_flush = 1'b1;
    bus.rob_pc = 32'h100;
    @(posedge clk); #1;
    bus.rob_flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("nodrop_en", 32'(bus.mc_en), 32'd1);
    check("nodrop_addr", bus.mc_addr, 32'h100);
    @(posedge clk); #1;
    wait_drain(60);

    begin_test("freeze");
    for (int i = 0; i < 5; i++) begin
      addr_q.push_back(32'(i * 4));
      exp_dec(ADDI, 32'(i * 4), 1'b0);
    end
    go();
    wait_req(32'h8, 60);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("frz_dec_en", 32'(bus.dec_en), 32'd0);
      check("frz_mc_en", 32'(bus.mc_en), 32'd1);
      check("frz_mc_addr", bus.mc_addr, 32'h8);
      check("frz_dec_pc", bus.dec_pc, 32'h4);
      @(posedge clk);
    end
    #1;
    rdy = 1'b1;
    wait_drain(80);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
